// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter sequencing one shared 8-bit adder (adder8 datapath).
// Optional macro ADDER_ARBITER_SUB_EN enables per-request subtraction (a - b).
module adder_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       sub0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic       sub1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       ovfl,
  output logic       cout,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic       opcin_q, opcin_d;
  logic [7:0] result_q, result_d;
  logic       ovfl_q, ovfl_d;
  logic       cout_q, cout_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;

  logic       gnt_sel;
  logic [7:0] b_sel;
  logic [8:0] sum9;
  logic       carry7;

  // On a tie the requester that was not served last wins.
  assign gnt_sel = (req0 && req1) ? ~last_q : req1;
  assign b_sel   = gnt_sel ? b1 : b0;

  // adder8 datapath: fed only from the operand registers.
  assign sum9   = {1'b0, opa_q} + {1'b0, opb_q} + {8'd0, opcin_q};
  assign carry7 = sum9[7] ^ opa_q[7] ^ opb_q[7];

`ifndef ADDER_ARBITER_SUB_EN
  logic unused_sub;
  assign unused_sub = sub0 ^ sub1;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opcin_d  = opcin_q;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    cout_d   = cout_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = gnt_sel;
          opa_d   = gnt_sel ? a1 : a0;
`ifdef ADDER_ARBITER_SUB_EN
          opb_d   = (gnt_sel ? sub1 : sub0) ? ~b_sel : b_sel;
          opcin_d = gnt_sel ? sub1 : sub0;
`else
          opb_d   = b_sel;
          opcin_d = 1'b0;
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = sum9[7:0];
        cout_d   = sum9[8];
        ovfl_d   = carry7 ^ sum9[8];
        ack0_d   = ~grant_q;
        ack1_d   = grant_q;
        state_d  = StResp;
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      opa_q    <= 8'h00;
      opb_q    <= 8'h00;
      opcin_q  <= 1'b0;
      result_q <= 8'h00;
      ovfl_q   <= 1'b0;
      cout_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opcin_q  <= opcin_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
      cout_q   <= cout_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign ovfl   = ovfl_q;
  assign cout   = cout_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter; honours ADDER_ARBITER_SUB_EN when defined.
module tb_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
  logic       ack0, ack1, ovfl, cout, busy;
  logic [7:0] result;

  int checks = 0;
  int failures = 0;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .ack0(ack0), .ack1(ack1), .result(result), .ovfl(ovfl), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Raise one request in an IDLE cycle, wait (bounded) for its ack, drop req after the ack cycle.
  task automatic run_op(input bit which, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, output int lat, output logic [7:0] r,
                        output logic o, output logic c, output logic other,
                        output logic [1:0] busy_seen);
    lat = -1; r = 8'hxx; o = 1'bx; c = 1'bx; other = 1'b0; busy_seen = 2'b00;
    if (!which) begin req0 = 1'b1; a0 = a; b0 = b; sub0 = sub; end
    else        begin req1 = 1'b1; a1 = a; b1 = b; sub1 = sub; end
    for (int i = 0; i < 10; i++) begin
      if (which ? ack0 : ack1) other = 1'b1;
      if (i == 1) busy_seen[0] = busy;
      if (i == 2) busy_seen[1] = busy;
      if (which ? ack1 : ack0) begin
        lat = i; r = result; o = ovfl; c = cout;
        break;
      end
      step();
    end
    step();
    req0 = 1'b0; req1 = 1'b0; sub0 = 1'b0; sub1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks += 6;
    if (ack0 !== 1'b0)    begin failures++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    if (ack1 !== 1'b0)    begin failures++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
    if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    if (ovfl !== 1'b0)    begin failures++; $display("FAIL reset_ovfl got=%b exp=0", ovfl); end
    if (cout !== 1'b0)    begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    int lat; logic [7:0] r; logic o, c, other; logic [1:0] bs;
    run_op(1'b0, 8'h05, 8'h03, 1'b0, lat, r, o, c, other, bs);
    checks += 7;
    if (lat !== 2)     begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    if (r !== 8'h08)   begin failures++; $display("FAIL add_result got=%h exp=08", r); end
    if (c !== 1'b0)    begin failures++; $display("FAIL add_cout got=%b exp=0", c); end
    if (o !== 1'b0)    begin failures++; $display("FAIL add_ovfl got=%b exp=0", o); end
    if (other !== 1'b0) begin failures++; $display("FAIL add_ack1_quiet got=%b exp=0", other); end
    if (bs !== 2'b11)  begin failures++; $display("FAIL add_busy got=%b exp=11", bs); end
    if (ack0 !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL add_idle_after ack0=%b busy=%b exp=0,0", ack0, busy); end
  endtask

  task automatic test_overflow();
    int lat; logic [7:0] r; logic o, c, other; logic [1:0] bs;
    run_op(1'b1, 8'h7F, 8'h01, 1'b0, lat, r, o, c, other, bs);
    checks += 5;
    if (lat !== 2)      begin failures++; $display("FAIL ovf_latency got=%0d exp=2", lat); end
    if (r !== 8'h80)    begin failures++; $display("FAIL ovf_result got=%h exp=80", r); end
    if (o !== 1'b1)     begin failures++; $display("FAIL ovf_ovfl got=%b exp=1", o); end
    if (c !== 1'b0)     begin failures++; $display("FAIL ovf_cout got=%b exp=0", c); end
    if (other !== 1'b0) begin failures++; $display("FAIL ovf_ack0_quiet got=%b exp=0", other); end
    step();
    run_op(1'b1, 8'hFF, 8'h01, 1'b0, lat, r, o, c, other, bs);
    checks += 4;
    if (lat !== 2)      begin failures++; $display("FAIL carry_latency got=%0d exp=2", lat); end
    if (r !== 8'h00)    begin failures++; $display("FAIL carry_result got=%h exp=00", r); end
    if (c !== 1'b1)     begin failures++; $display("FAIL carry_cout got=%b exp=1", c); end
    if (o !== 1'b0)     begin failures++; $display("FAIL carry_ovfl got=%b exp=0", o); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int cyc [4];
    logic who [4];
    logic [7:0] res [4];
    logic both = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 30 && n < 4; i++) begin
      if (ack0 && ack1) both = 1'b1;
      if (ack0 || ack1) begin
        cyc[n] = i; who[n] = ack1; res[n] = result; n++;
      end
      if (n < 4) step();
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    checks += 2;
    if (n !== 4)       begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
    if (both !== 1'b0) begin failures++; $display("FAIL b2b_exclusive got=%b exp=0", both); end
    for (int k = 0; k < n; k++) begin
      checks += 3;
      if (who[k] !== k[0])
        begin failures++; $display("FAIL b2b_order%0d got=%b exp=%b", k, who[k], k[0]); end
      if (cyc[k] !== 2 + 3 * k)
        begin failures++; $display("FAIL b2b_cycle%0d got=%0d exp=%0d", k, cyc[k], 2 + 3 * k); end
      if (res[k] !== (k[0] ? 8'h04 : 8'h02))
        begin failures++; $display("FAIL b2b_result%0d got=%h exp=%h", k, res[k],
                                   k[0] ? 8'h04 : 8'h02); end
    end
    step();
  endtask

  task automatic test_sub();
    int lat; logic [7:0] r; logic o, c, other; logic [1:0] bs;
    logic [7:0] exp_r;
`ifdef ADDER_ARBITER_SUB_EN
    exp_r = 8'hFE;
`else
    exp_r = 8'h0C;
`endif
    run_op(1'b0, 8'h05, 8'h07, 1'b1, lat, r, o, c, other, bs);
    checks += 4;
    if (lat !== 2)   begin failures++; $display("FAIL sub_latency got=%0d exp=2", lat); end
    if (r !== exp_r) begin failures++; $display("FAIL sub_result got=%h exp=%h", r, exp_r); end
    if (c !== 1'b0)  begin failures++; $display("FAIL sub_cout got=%b exp=0", c); end
    if (o !== 1'b0)  begin failures++; $display("FAIL sub_ovfl got=%b exp=0", o); end
  endtask

  task automatic test_reset_mid();
    int lat = -1;
    logic early = 1'b0;
    logic [7:0] r = 8'hxx;
    req0 = 1'b1; a0 = 8'h10; b0 = 8'h20; sub0 = 1'b0;
    step();
    checks += 1;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_exec_busy got=%b exp=1", busy); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (result !== 8'h00) begin failures++; $display("FAIL rstmid_result got=%h exp=00", result); end
    if (cout !== 1'b0)    begin failures++; $display("FAIL rstmid_cout got=%b exp=0", cout); end
    if (ack0 !== 1'b0)    begin failures++; $display("FAIL rstmid_ack0 got=%b exp=0", ack0); end
    step();
    if (ack0) early = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ack0) begin lat = i; r = result; break; end
      step();
    end
    step();
    req0 = 1'b0;
    checks += 3;
    if (early !== 1'b0) begin failures++; $display("FAIL rstmid_no_ack got=%b exp=0", early); end
    if (lat !== 2)      begin failures++; $display("FAIL rstmid_latency got=%0d exp=2", lat); end
    if (r !== 8'h30)    begin failures++; $display("FAIL rstmid_result_after got=%h exp=30", r); end
  endtask

  task automatic test_drop();
    int pulses = 0;
    logic [7:0] r = 8'hxx;
    step();
    req0 = 1'b1; a0 = 8'h03; b0 = 8'h04;
    step();
    req0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ack0) begin pulses++; r = result; end
      step();
    end
    checks += 3;
    if (pulses !== 1)  begin failures++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    if (r !== 8'h07)   begin failures++; $display("FAIL drop_result got=%h exp=07", r); end
    if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    step();
    test_overflow();
    test_back_to_back();
    test_sub();
    step();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
